// File: rtl/pipeifq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Imported by the queue storage and the fetch controller.
package pipeifq_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } ifq_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of {pc, inst} entries with push, pop and flush.
// The head entry is read straight from registered storage.
module ifq_fifo
   import pipeifq_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  ifq_entry_t    wdata_i,
   output ifq_entry_t    rdata_o,
   output logic [CW-1:0] count_o
);

   ifq_entry_t    mem_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign do_push = push_i && (cnt_q != CW'(DEPTH));
   assign do_pop  = pop_i && (cnt_q != '0);

   // Pointer and occupancy update; flush beats push and pop.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) tail_d = tail_q + PW'(1);
         if (do_pop)  head_d = head_q + PW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage and pointer registers; reset also zeroes every slot.
   always_ff @(posedge clk) begin
      if (clr) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         if (do_push && !flush_i) begin
            mem_q[tail_q] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q[head_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/pipeifq.sv
// Prefetch queue: owns the fetch pointer, issues one memory read at a
// time, and hands buffered words to decode; a redirect flushes it.
module pipeifq
   import pipeifq_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        clr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        id_ready,
   input  logic        redir,
   input  logic [31:0] redir_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   ifq_state_e    state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          drop_q, drop_d;
   logic [CW-1:0] count, cnt_nx;
   logic          rsp, push, pop;
   ifq_entry_t    head, wentry;
   logic          redir_lsb_unused;

   assign redir_lsb_unused = ^redir_pc[1:0];

   assign rsp    = (state_q == ST_WAIT) && mem_rvalid;
   assign push   = rsp && !drop_q && !redir;
   assign pop    = inst_valid && id_ready && !redir;
   assign cnt_nx = count + CW'(push) - CW'(pop);
   assign wentry = '{pc: addr_q, inst: mem_rdata};

   ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .clr     (clr),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redir),
      .wdata_i (wentry),
      .rdata_o (head),
      .count_o (count)
   );

   // State, fetch pointer, request address and drop flag registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         drop_q     <= drop_d;
      end
   end

   // Next state: request only while a slot is free for the reply.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!redir && (count < CW'(DEPTH))) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (mem_gnt) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               if (redir || (cnt_nx < CW'(DEPTH))) state_d = ST_REQ;
               else state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pointer/drop update; a redirect overrides the post-grant step.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      addr_d     = addr_q;
      if ((state_q == ST_REQ) && mem_gnt && !drop_q && !redir) begin
         fetch_pc_d = fetch_pc_q + PC_INC;
      end
      if (rsp) drop_d = 1'b0;
      if (redir) begin
         fetch_pc_d = {redir_pc[31:2], 2'b00};
         if ((state_q == ST_REQ) ||
             ((state_q == ST_WAIT) && !mem_rvalid)) begin
            drop_d = 1'b1;
         end
      end
      if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
         addr_d = fetch_pc_d;
      end
   end

   // Memory-side outputs come straight from registers.
   always_comb begin
      mem_req  = (state_q == ST_REQ);
      mem_addr = addr_q;
   end

   assign inst_valid = (count != '0);
   assign inst       = head.inst;
   assign inst_pc    = head.pc;

endmodule

// File: doc/pipeifq.md
Name: pipeifq

Overview:
Instruction prefetch queue for the pipelined CPU, sitting between instruction memory and the IF/ID pipeline register. It owns the fetch pointer and issues sequential word reads to instruction memory through a request/grant/response handshake. It buffers returned words with their PCs and presents them in order to the decode stage under a valid/ready handshake. A branch/jump redirect from the pipeline flushes the queue and restarts fetch at the target.

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned)

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  synchronous active-high reset
mem_req  out  1  read request to instruction memory
mem_addr  out  32  word-aligned read address, valid while mem_req=1
mem_gnt  in  1  memory accepts request this cycle (mem_req&mem_gnt)
mem_rvalid  in  1  read data valid, ≥1 cycle after the grant
mem_rdata  in  32  instruction word
inst_valid  out  1  head entry available to decode
inst  out  32  head instruction
inst_pc  out  32  PC of head instruction
id_ready  in  1  decode consumes head when inst_valid&id_ready
redir  in  1  flush and restart fetch
redir_pc  in  32  restart address (bits[1:0] ignored, treated as 0)

Behaviour:
- Reset (clr=1 at edge): fetch_pc=RESET_PC, count=0, head/tail=0, state=IDLE, drop=0, storage cleared; mem_req=0, inst_valid=0, inst=0, inst_pc=0. Reset mid-transaction abandons it; a later mem_rvalid belonging to it is ignored while state=IDLE.
- At most one outstanding memory transaction.
- FSM:
  IDLE: if count+0 < DEPTH and not redir → REQ (mem_req rises next cycle).
  REQ: mem_req=1, mem_addr=fetch_pc held stable; on mem_gnt → WAIT, fetch_pc+=4.
  WAIT: on mem_rvalid → enqueue {mem_rdata, pc_of_req} unless drop; clear drop; → REQ if space remains after this cycle's enqueue/dequeue, else IDLE.
- Space rule: a request is issued (REQ entered) only when count < DEPTH, counting the slot the outstanding response will fill; response never finds the queue full.
- Once asserted, mem_req is never withdrawn before mem_gnt (even on redirect).
- Redirect (redir=1) takes priority over same-cycle enqueue and dequeue: count→0, fetch_pc←{redir_pc[31:2],2'b00}; if state REQ or WAIT, drop←1 and the in-flight response is discarded; a REQ in progress completes its grant with the old address, then fetch_pc is NOT incremented (stays at redir target). inst_valid=0 the cycle after redir.
- Redirect while drop=1: fetch_pc updated, drop stays 1.
- Simultaneous enqueue and dequeue: count unchanged.
- fetch_pc increments by 4, wraps 32'hFFFF_FFFC → 0.
- Outputs: inst_valid=(count≠0); inst/inst_pc from head entry (registered storage, no combinational path from mem_rdata). Latency: granted word visible on inst the cycle after mem_rvalid.
- Throughput with 1-cycle grant and 1-cycle response: one word per 2 cycles (single outstanding).

Decomposition:
- Shared package: PC/instruction width (32), word increment constant (4), FSM state encoding {IDLE, REQ, WAIT}.
- One sub-module: ifq_fifo (DEPTH×64-bit circular buffer with head/tail/count, push/pop/flush); pipeifq holds the FSM, fetch pointer and drop flag.

Test Plan:
- Reset, memory gnt=1 every cycle, rvalid 1 cycle after gnt, data=addr^32'hA5A5_0000, id_ready=1 → mem_addr 0,4,8…; inst_pc 0,4,8 in order with matching inst.
- id_ready=0 for 20 cycles → exactly DEPTH=4 requests issued, mem_req stays 0 afterward, inst_pc holds 0; release → 4 words drain in order, fetch resumes at 0x10.
- redir=1, redir_pc=0x0000_1003 while in WAIT → next response discarded, next mem_addr=0x1000, first inst_pc=0x1000, inst_valid=0 the cycle after redir.
- redir while in REQ with gnt delayed 3 cycles → mem_req/mem_addr stay stable until gnt, returned word dropped, next request to redir target.
- RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- clr asserted while in WAIT, stray mem_rvalid after → inst_valid remains 0, first new request at RESET_PC.
